// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART engine.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OS_RATE   = 16;
    localparam int DATA_BITS = 8;

    function automatic int calc_os_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: rxd synchroniser, 16x oversampled framing FSM and shift register.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk_bus,
    input  logic       rst_bus,
    input  logic       os_tick,
    input  logic       rxd,
    output logic [7:0] dat,
    output logic       ready,
    output logic       frame_err
);

    localparam logic [3:0] MID_CNT  = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OS_RATE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic        rxd_s1, rxd_s2, rxd_s3;
    uart_state_t rx_state;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            rxd_s1    <= 1'b1;
            rxd_s2    <= 1'b1;
            rxd_s3    <= 1'b1;
            rx_state  <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            dat       <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxd_s1    <= rxd;
            rxd_s2    <= rxd_s1;
            rxd_s3    <= rxd_s2;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                // Only a 1->0 edge arms RX, so a held-low break cannot re-trigger.
                IDLE: begin
                    if (rxd_s3 && !rxd_s2) begin
                        rx_state <= START;
                        os_cnt   <= '0;
                    end
                end
                START: begin
                    if (os_tick) begin
                        if (os_cnt == MID_CNT) begin
                            os_cnt  <= '0;
                            bit_idx <= '0;
                            rx_state <= rxd_s2 ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (os_tick) begin
                        if (os_cnt == LAST_CNT) begin
                            os_cnt  <= '0;
                            shift   <= {rxd_s2, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == LAST_BIT)
                                rx_state <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (os_tick) begin
                        if (os_cnt == LAST_CNT) begin
                            os_cnt   <= '0;
                            rx_state <= IDLE;
                            if (rxd_s2) begin
                                dat   <= shift;
                                ready <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART engine: start/busy transmitter, oversample tick generator and receiver.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 11059200,
    parameter int BAUD     = 115200
) (
    input  logic       clk_bus,
    input  logic       rst_bus,
    input  logic       uart_start,
    input  logic [7:0] uart_dat_i,
    output logic       uart_busy,
    output logic [7:0] uart_dat_o,
    output logic       uart_ready,
    output logic       frame_err,
    output logic       txd,
    input  logic       rxd
);

    localparam int OS_DIV   = calc_os_div(CLK_FREQ, BAUD);
    localparam int OS_W     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int BIT_CLKS = OS_RATE * OS_DIV;
    localparam int BT_W     = $clog2(BIT_CLKS);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [OS_W-1:0] os_cnt;
    logic            os_tick;

    assign os_tick = (os_cnt == OS_W'(OS_DIV - 1));

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus)
            os_cnt <= '0;
        else if (os_tick)
            os_cnt <= '0;
        else
            os_cnt <= os_cnt + 1'b1;
    end

    // TX keeps its own bit timer so frames line up with the accepting clock.
    uart_state_t     tx_state;
    logic [BT_W-1:0] tx_timer;
    logic [2:0]      tx_idx;
    logic [7:0]      tx_shift;
    logic            bit_end;

    assign bit_end = (tx_timer == BT_W'(BIT_CLKS - 1));

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            tx_state  <= IDLE;
            tx_timer  <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            txd       <= 1'b1;
            uart_busy <= 1'b0;
        end else begin
            tx_timer <= bit_end ? '0 : tx_timer + 1'b1;
            case (tx_state)
                IDLE: begin
                    if (uart_start && !uart_busy) begin
                        tx_shift  <= uart_dat_i;
                        tx_timer  <= '0;
                        tx_state  <= START;
                        txd       <= 1'b0;
                        uart_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_state <= DATA;
                        tx_idx   <= '0;
                        txd      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (tx_idx == LAST_BIT) begin
                            tx_state <= STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            txd      <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_state  <= IDLE;
                        uart_busy <= 1'b0;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    uart_rx u_rx (
        .clk_bus   (clk_bus),
        .rst_bus   (rst_bus),
        .os_tick   (os_tick),
        .rxd       (rxd),
        .dat       (uart_dat_o),
        .ready     (uart_ready),
        .frame_err (frame_err)
    );

endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core with a frame-level reference model (16 clocks per bit).
module tb_uart_core;

    localparam int BIT = 16;

    logic       clk_bus;
    logic       rst_bus;
    logic       uart_start;
    logic [7:0] uart_dat_i;
    logic       uart_busy;
    logic [7:0] uart_dat_o;
    logic       uart_ready;
    logic       frame_err;
    logic       txd;
    logic       rxd;
    logic       rxd_drv;
    logic       loop_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int rdy_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] rdy_byte = '0;
    logic [7:0] model_dat;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_core #(
        .CLK_FREQ (1843200),
        .BAUD     (115200)
    ) dut (
        .clk_bus    (clk_bus),
        .rst_bus    (rst_bus),
        .uart_start (uart_start),
        .uart_dat_i (uart_dat_i),
        .uart_busy  (uart_busy),
        .uart_dat_o (uart_dat_o),
        .uart_ready (uart_ready),
        .frame_err  (frame_err),
        .txd        (txd),
        .rxd        (rxd)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    always @(posedge clk_bus) cyc <= cyc + 1;

    // Output event monitor, sampled mid-cycle.
    always @(negedge clk_bus) begin
        if (uart_ready) begin
            rdy_cnt  <= rdy_cnt + 1;
            rdy_byte <= uart_dat_o;
            rdy_cyc  <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (uart_ready && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (uart_busy && n < 400) begin
            @(negedge clk_bus);
            n++;
        end
        if (uart_busy) chk("tx_idle_timeout", 32'd1, 32'd0);
    endtask

    // Sends one byte from a negedge where busy is low; checks busy length and line bits.
    task automatic tx_frame(input logic [7:0] b, input bit inject);
        logic [9:0] exp_bits;
        logic [9:0] got;
        int busy_cnt;
        exp_bits = {1'b1, b, 1'b0};
        got = '0;
        uart_start = 1'b1;
        uart_dat_i = b;
        @(negedge clk_bus);
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < BIT; j++) begin
                if (j == BIT / 2) got[k] = txd;
                if (uart_busy) busy_cnt++;
                if (inject && k == 3 && j == 4) begin
                    uart_start = 1'b1;
                    uart_dat_i = 8'h3C;
                end else begin
                    uart_start = 1'b0;
                    uart_dat_i = 8'($urandom);
                end
                @(negedge clk_bus);
            end
        end
        chk("tx_busy_len", busy_cnt, 160);
        chk("tx_busy_end", uart_busy, 1'b0);
        chk("tx_bits", got, exp_bits);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        fall_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            rxd_drv = bits[k];
            repeat (BIT) @(negedge clk_bus);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic rx_check(input logic [7:0] b, input logic stop_bit);
        int r0, e0, lat;
        r0 = rdy_cnt;
        e0 = err_cnt;
        rx_send(b, stop_bit);
        repeat (20) @(negedge clk_bus);
        if (stop_bit) begin
            model_dat = b;
            lat = rdy_cyc - fall_cyc;
            chk("rx_ready_cnt", rdy_cnt, r0 + 1);
            chk("rx_byte", rdy_byte, b);
            chk("rx_latency_ok", (lat >= 150 && lat <= 160), 1);
            chk("rx_no_err", err_cnt, e0);
        end else begin
            chk("rx_err_cnt", err_cnt, e0 + 1);
            chk("rx_err_no_ready", rdy_cnt, r0);
        end
        chk("rx_dat_o", uart_dat_o, model_dat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, e0;
        logic [7:0] b;
        logic [7:0] lb [5];

        rst_bus    = 1'b0;
        uart_start = 1'b0;
        uart_dat_i = '0;
        rxd_drv    = 1'b1;
        loop_en    = 1'b0;
        model_dat  = '0;
        repeat (4) @(negedge clk_bus);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", uart_busy, 1'b0);
        chk("rst_dat_o", uart_dat_o, 8'h00);
        chk("rst_ready", uart_ready, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        rst_bus = 1'b1;
        repeat (5) @(negedge clk_bus);

        // TX: A5 with an ignored mid-frame request, then 81 back-to-back.
        tx_frame(8'hA5, 1'b1);
        tx_frame(8'h81, 1'b0);
        repeat (3) @(negedge clk_bus);
        chk("tx_no_retrigger", uart_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk_bus);
            wait_idle();
            tx_frame(8'($urandom), 1'b0);
        end

        // RX: good frame, glitch, bad stop, break, random frames.
        rx_check(8'h5A, 1'b1);
        r0 = rdy_cnt;
        e0 = err_cnt;
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk_bus);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk_bus);
        chk("glitch_no_ready", rdy_cnt, r0);
        chk("glitch_no_err", err_cnt, e0);
        rx_check(8'h0F, 1'b0);
        r0 = rdy_cnt;
        e0 = err_cnt;
        rxd_drv = 1'b0;
        repeat (400) @(negedge clk_bus);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk_bus);
        chk("break_one_err", err_cnt, e0 + 1);
        chk("break_no_ready", rdy_cnt, r0);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            rx_check(b, 1'b1);
            repeat ($urandom_range(0, 10)) @(negedge clk_bus);
        end

        // Loopback.
        loop_en = 1'b1;
        repeat (10) @(negedge clk_bus);
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h55;
        lb[3] = 8'($urandom);
        lb[4] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            r0 = rdy_cnt;
            wait_idle();
            tx_frame(lb[i], 1'b0);
            repeat (4) @(negedge clk_bus);
            chk("loop_ready_cnt", rdy_cnt, r0 + 1);
            chk("loop_byte", rdy_byte, lb[i]);
        end

        // Reset in the middle of a looped-back frame.
        r0 = rdy_cnt;
        e0 = err_cnt;
        uart_start = 1'b1;
        uart_dat_i = 8'($urandom);
        @(negedge clk_bus);
        uart_start = 1'b0;
        repeat (60) @(negedge clk_bus);
        #2;
        rst_bus = 1'b0;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_busy", uart_busy, 1'b0);
        @(negedge clk_bus);
        chk("midrst_dat_o", uart_dat_o, 8'h00);
        repeat (3) @(negedge clk_bus);
        rst_bus = 1'b1;
        repeat (250) @(negedge clk_bus);
        chk("midrst_no_ready", rdy_cnt, r0);
        chk("midrst_no_err", err_cnt, e0);
        b = 8'($urandom);
        tx_frame(b, 1'b0);
        repeat (4) @(negedge clk_bus);
        chk("post_rst_ready", rdy_cnt, r0 + 1);
        chk("post_rst_byte", rdy_byte, b);
        chk("ready_err_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- 8N1 UART engine that sits under the bus-side serial slave.
- Accepts transmit bytes on a start/busy handshake and serialises them on txd.
- Deserialises rxd and presents each received byte with a one-cycle ready strobe.
- Single clock domain, so the bus-side slave can run on the same clock.

Parameters:
CLK_FREQ, 11059200, input clock frequency in Hz
BAUD, 115200, line rate in bits/s
OS_DIV, CLK_FREQ/(BAUD*16), derived localparam: clocks per 16x-oversample tick; must be >= 1

Ports:
clk_bus  in  1  system clock
rst_bus  in  1  reset, asynchronous, active-low
uart_start  in  1  transmit request, sampled only while uart_busy==0
uart_dat_i  in  8  byte to transmit, captured with an accepted uart_start
uart_busy  out  1  transmitter occupied
uart_dat_o  out  8  last correctly framed received byte
uart_ready  out  1  one-cycle pulse: uart_dat_o updated
frame_err  out  1  one-cycle pulse: stop bit sampled low
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous

Behaviour:
- Reset: txd=1, uart_busy=0, uart_dat_o=0, uart_ready=0, frame_err=0, both FSMs IDLE, rxd synchroniser preset to 1. Reset mid-frame aborts immediately; txd returns to 1 asynchronously.
- All outputs are registered.
- Oversample tick: free-running counter 0..OS_DIV-1, tick on wrap. Used by RX only.
- TX timer: a private counter restarts on start acceptance, so TX bit edges align to acceptance.
- Bit period is exactly 16*OS_DIV clocks.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if uart_start && !uart_busy, latch uart_dat_i. Next cycle uart_busy=1, txd=0, state START.
  - START: one bit period, then DATA.
  - DATA: 8 bits LSB first, bit index 0..7, one bit period each.
  - STOP: txd=1 for one bit period. uart_busy=0 the cycle after STOP ends.
  - A start pulse in that same cycle is accepted, giving back-to-back frames with no idle gap.
  - Frame length: uart_busy high for exactly 160*OS_DIV clocks.
  - uart_start while busy is ignored; no queuing. uart_dat_i changes while busy have no effect.
  - A level-held uart_start retriggers each time busy drops; the master must deassert it.
- RX input: 2-flop synchroniser on rxd, plus a third flop for falling-edge detect.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, with an oversample counter 0..15 per bit.
  - IDLE: synchronised falling edge (1->0) enters START, counter cleared.
  - START: at tick count 7 (mid-bit), resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA with counter cleared.
  - DATA: sample every 16 ticks (mid-bit), shift in LSB first; after 8 samples go to STOP.
  - STOP: sample after 16 ticks.
  - Stop=1: uart_dat_o <= shift register and uart_ready=1 for one clock.
  - Stop=0: frame_err=1 for one clock, uart_dat_o unchanged. RX then waits for the line to be high before re-arming (break does not generate repeated frames).
  - Return to IDLE at the stop-bit mid-point, so a back-to-back start bit is caught.
- uart_ready and frame_err are never high together.
- An unread byte is overwritten by the next frame; there is no overrun flag.
- TX and RX are fully independent; simultaneous start and receive have no interaction.

Decomposition:
- Shared package: UART state enum (IDLE, START, DATA, STOP), OS_RATE=16, DATA_BITS=8, and an OS_DIV computation function.
- One natural sub-module, uart_rx, holding the synchroniser, RX FSM and shift register.
- TX, the tick generator and uart_rx are instantiated in uart_core.

Test Plan:
(Bench uses CLK_FREQ=1843200, BAUD=115200, so OS_DIV=1 and bit=16 clocks.)
1. TX basic: release reset; pulse uart_start 1 clk with uart_dat_i=0xA5 -> busy next clk for exactly 160 clks; txd sequence per 16 clks is 0,1,0,1,0,0,1,0,1,1.
2. TX back-to-back and ignore: assert uart_start 0x3C during busy -> ignored. Start 0x81 in the cycle busy falls -> second frame begins with zero idle clocks.
3. RX basic: drive rxd frame for 0x5A at 16 clks/bit -> uart_ready one-clock pulse, uart_dat_o=0x5A, frame_err=0. Timing: pulse ~152 clks after the falling edge, plus synchroniser delay.
4. RX error and glitch: 4-clk low glitch -> no output, RX idle. Frame 0x0F with stop bit 0 -> frame_err pulse, uart_dat_o keeps its prior 0x5A. Holding rxd low 400 clks -> only one frame_err.
5. Loopback plus reset: tie txd to rxd, send 0x00, 0xFF, 0x55 -> three ready pulses with matching bytes. Assert rst_bus low mid-frame -> txd=1 and busy=0 immediately; no ready pulse is produced.
